// File: rtl/f1_seq_pkg.sv
// rtl/f1_seq_pkg.sv - shared types and defaults for the F1 start-light sequencer
//
// Contents:
//   seq_state_e        sequencer state encoding (IDLE, STEP, HOLD, DONE)
//   DEF_NUM_LIGHTS     default number of lamp outputs
//   DEF_CNT_W          default width of period inputs and the step timer
package f1_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    localparam int DEF_NUM_LIGHTS = 10;
    localparam int DEF_CNT_W      = 14;

endpackage : f1_seq_pkg

// File: rtl/f1_light_seq_step_timer.sv
// rtl/f1_light_seq_step_timer.sv - period counter shared by the STEP and HOLD phases
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   clear   in   hold the count at 0 for the next cycle
//   period  in   cycles per expiry; 0 behaves as 1
//   expire  out  high in the cycle where the count has reached period-1
//
// The count restarts from 0 on its own after each expiry, so it never
// runs past period-1 and never wraps.
module step_timer
    import f1_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [CNT_W-1:0] period,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] last_count;

    always_comb begin
        // A zero period is treated as one cycle rather than underflowing.
        last_count = (period == '0) ? '0 : period - CNT_W'(1);
        expire     = (count_q == last_count);
        count_d    = (clear || expire) ? '0 : count_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : step_timer

// File: rtl/f1_light_seq.sv
// rtl/f1_light_seq.sv - F1 start-light sequencer: lamps light one by one, hold, then release
//
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   start   in   sequence request, accepted only in IDLE
//   abort   in   cancels any sequence; wins over every other transition
//   step_n  in   cycles per lamp step (latched at start)
//   hold_n  in   cycles all lamps stay lit (latched at start when HOLD is configurable)
//   lights  out  lamp drive, bit 0 lit first
//   busy    out  high while a sequence is active
//   done    out  one-cycle pulse on normal completion
//
// Build option: F1_LIGHT_SEQ_HOLD_EN
//   defined   - HOLD lasts the latched hold_n cycles (0 behaves as 1)
//   undefined - HOLD lasts exactly one cycle; hold_n is ignored
module f1_light_seq
    import f1_seq_pkg::*;
#(
    parameter int NUM_LIGHTS = DEF_NUM_LIGHTS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CNT_W-1:0]      step_n,
    input  logic [CNT_W-1:0]      hold_n,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic                  busy,
    output logic                  done
);

    localparam int IDX_W = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIGHTS - 1);

    seq_state_e            state_q, state_d;
    logic [NUM_LIGHTS-1:0] lights_q, lights_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      step_per_q, step_per_d;
    logic [CNT_W-1:0]      hold_per;
    logic [CNT_W-1:0]      timer_period;
    logic                  timer_clear;
    logic                  timer_expire;

`ifdef F1_LIGHT_SEQ_HOLD_EN
    logic [CNT_W-1:0]      hold_per_q, hold_per_d;
    assign hold_per = hold_per_q;
`else
    logic                  unused_hold;
    assign unused_hold = ^hold_n;
    assign hold_per    = CNT_W'(1);
`endif

    // One timer serves both timed phases; it is cleared on every phase change.
    assign timer_period = (state_q == ST_HOLD) ? hold_per : step_per_q;

    step_timer #(
        .CNT_W (CNT_W)
    ) u_step_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .period (timer_period),
        .expire (timer_expire)
    );

    always_comb begin
        state_d     = state_q;
        lights_d    = lights_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        idx_d       = idx_q;
        step_per_d  = step_per_q;
`ifdef F1_LIGHT_SEQ_HOLD_EN
        hold_per_d  = hold_per_q;
`endif
        // The timer only runs in STEP and HOLD; everywhere else it sits at 0.
        timer_clear = 1'b1;

        if (abort) begin
            state_d  = ST_IDLE;
            lights_d = '0;
            busy_d   = 1'b0;
            idx_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        step_per_d = step_n;
`ifdef F1_LIGHT_SEQ_HOLD_EN
                        hold_per_d = hold_n;
`endif
                        idx_d      = '0;
                        lights_d   = '0;
                        busy_d     = 1'b1;
                        state_d    = ST_STEP;
                    end
                end
                ST_STEP: begin
                    timer_clear = 1'b0;
                    if (timer_expire) begin
                        lights_d[idx_q] = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            idx_d   = '0;
                            state_d = ST_HOLD;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    timer_clear = 1'b0;
                    if (timer_expire) begin
                        lights_d = '0;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            lights_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            idx_q      <= '0;
            step_per_q <= '0;
`ifdef F1_LIGHT_SEQ_HOLD_EN
            hold_per_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            lights_q   <= lights_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            idx_q      <= idx_d;
            step_per_q <= step_per_d;
`ifdef F1_LIGHT_SEQ_HOLD_EN
            hold_per_q <= hold_per_d;
`endif
        end
    end

    assign lights = lights_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule : f1_light_seq

// File: tb/tb_f1_light_seq.sv
// tb/tb_f1_light_seq.sv - directed self-checking bench for f1_light_seq (4 lamps, 14-bit periods)
module tb_f1_light_seq;

    localparam int NL = 4;
    localparam int CW = 14;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          start  = 1'b0;
    logic          abort  = 1'b0;
    logic [CW-1:0] step_n = '0;
    logic [CW-1:0] hold_n = '0;
    logic [NL-1:0] lights;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fails  = 0;

    f1_light_seq #(
        .NUM_LIGHTS (NL),
        .CNT_W      (CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .step_n (step_n),
        .hold_n (hold_n),
        .lights (lights),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Expected {lights, busy, done} just after edge e of a run started at edge 0,
    // with effective step s and hold h: lamp i lights at (i+1)*s, all lamps
    // stay lit until NL*s+h, where done pulses for one cycle.
    function automatic logic [NL+1:0] expect_at(int e, int s, int h);
        int end_e;
        logic [NL-1:0] lit;
        end_e = NL * s + h;
        if (e < NL * s) begin
            lit = NL'((1 << (e / s)) - 1);
            return {lit, 2'b10};
        end else if (e < end_e) begin
            return {{NL{1'b1}}, 2'b10};
        end else if (e == end_e) begin
            return {{NL{1'b0}}, 2'b01};
        end
        return '0;
    endfunction

    task automatic check(string tag, logic [NL+1:0] exp);
        n_checks++;
        assert ({lights, busy, done} === exp) else begin
            n_fails++;
            $error("FAIL %s observed={lights,busy,done}=%b expected=%b", tag, {lights, busy, done}, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one sequence from start at edge 0 through one edge past done.
    // abort_e: edge at which abort is sampled (-1 none); start2_e: edge of an
    // extra start pulse (-1 none); chg_e: edge from which step_n reads 9 (-1 none).
    task automatic run(string tag, int s, int h, int abort_e, int start2_e, int chg_e);
        int se;
        int he;
        int last;
        se = (s == 0) ? 1 : s;
`ifdef F1_LIGHT_SEQ_HOLD_EN
        he = (h == 0) ? 1 : h;
`else
        he = 1;
`endif
        last = NL * se + he + 1;
        for (int e = 0; e <= last; e++) begin
            start  = (e == 0) || (e == start2_e);
            abort  = (e == abort_e);
            step_n = (chg_e >= 0 && e >= chg_e) ? CW'(9) : CW'(s);
            hold_n = CW'(h);
            tick();
            if (abort_e >= 0 && e >= abort_e)
                check($sformatf("%s@%0d", tag, e), '0);
            else
                check($sformatf("%s@%0d", tag, e), expect_at(e, se, he));
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        // Asynchronous reset takes effect without a clock edge.
        #2 rst_n = 1'b0;
        #2 check("reset_async", '0);
        tick();
        check("reset_clocked", '0);
        rst_n = 1'b1;
        tick();
        check("idle_after_reset", '0);

        // Normal run: lamps at 3,6,9,12; done at 12+hold.
        run("normal", 3, 5, -1, -1, -1);

        // Zero periods behave as 1: lamps at edges 1-4, done at 5.
        run("zero", 0, 0, -1, -1, -1);

        // Abort at edge 7 clears everything, no done pulse; then a restart works.
        run("abort", 3, 5, 7, -1, -1);
        run("restart", 2, 2, -1, -1, -1);

        // Start and abort together in IDLE leaves the sequencer idle.
        start = 1'b1;
        abort = 1'b1;
        step_n = CW'(3);
        tick();
        check("start_abort_idle", '0);
        start = 1'b0;
        abort = 1'b0;
        tick();
        check("still_idle", '0);

        // Mid-sequence start at edge 5 and step_n change at edge 4 have no effect.
        run("prio", 3, 5, -1, 5, 4);

        // Reset asserted between edges 8 and 9 clears outputs before edge 9.
        for (int e = 0; e <= 8; e++) begin
            start  = (e == 0);
            step_n = CW'(3);
            hold_n = CW'(5);
            tick();
            check($sformatf("rst_run@%0d", e), expect_at(e, 3, 5));
        end
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("rst_mid_async", '0);
        tick();
        check("rst_mid_edge9", '0);
        rst_n = 1'b1;
        for (int e = 10; e <= 20; e++) begin
            tick();
            check($sformatf("rst_nodone@%0d", e), '0);
        end
        run("post_rst", 3, 5, -1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_f1_light_seq

// File: doc/f1_light_seq.md
F1_LIGHT_SEQ -- requirements
Module: f1_light_seq

Interface
REQ-001 SHALL have parameter NUM_LIGHTS, default 10, meaning number of lamp outputs lit in sequence (2..16).
REQ-002 SHALL have parameter CNT_W, default 14, meaning the width of the period inputs and the internal timer.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, a sequence request sampled on clk.
REQ-006 SHALL have port abort, input, 1, which cancels any sequence in progress.
REQ-007 SHALL have port step_n, input, CNT_W, the clock cycles per lamp step.
REQ-008 SHALL have port hold_n, input, CNT_W, the clock cycles all lamps stay lit before release.
REQ-009 SHALL have port lights, output, NUM_LIGHTS, the lamp drive, bit 0 lit first.
REQ-010 SHALL have port busy, output, 1, high while a sequence is active.
REQ-011 SHALL have port done, output, 1, a single-cycle pulse on normal completion.

Function
REQ-012 SHALL implement states IDLE, STEP, HOLD and DONE, all outputs registered.
REQ-013 SHALL, in IDLE with start=1 and abort=0, latch step_n and hold_n, clear the timer and lamp index, go to STEP and set busy at that edge.
REQ-014 SHALL ignore start outside IDLE; latched periods SHALL NOT change mid-sequence.
REQ-015 SHALL treat a latched period of 0 as 1, with no counter wrap-around.
REQ-016 SHALL, in STEP, increment the timer each cycle; when timer == step-1 it SHALL set lights[idx], clear the timer and increment idx.
REQ-017 SHALL light lamp i at edge (i+1)*step after the start edge (edge 0).
REQ-018 SHALL go to HOLD with the timer cleared when lamp NUM_LIGHTS-1 is lit.
REQ-019 SHALL, in HOLD, increment the timer; when timer == hold-1 it SHALL clear lights to 0 and go to DONE.
REQ-020 SHALL, in DONE, assert done=1 and busy=0 for exactly one cycle, then return to IDLE; start in DONE is ignored.
REQ-021 SHALL give abort priority over start and all other transitions: next edge is IDLE, lights=0, busy=0, done=0, timer cleared.
REQ-022 SHALL set lamp bits only while in STEP; lamp bits SHALL never clear individually.

Reset
REQ-023 SHALL, while rst_n=0, immediately force state=IDLE, lights=0, busy=0, done=0, timer=0, idx=0 and latched periods=0, independent of clk.
REQ-024 SHALL, on reset mid-sequence, produce no done pulse; the first start accepted after release SHALL begin a fresh sequence.

Configuration
REQ-025 SHALL use macro F1_LIGHT_SEQ_HOLD_EN: when defined, HOLD duration = latched hold_n per REQ-019.
REQ-026 SHALL, when F1_LIGHT_SEQ_HOLD_EN is undefined, fix HOLD at exactly 1 cycle; hold_n SHALL remain a port but be ignored and not latched.

Structure
REQ-027 SHALL define the state enum typedef and default NUM_LIGHTS/CNT_W constants in shared package f1_seq_pkg.
REQ-028 SHALL implement the period counter as sub-module step_timer (ports: clk, rst_n, clear, period, expire), instantiated once and shared by STEP and HOLD.

Verification (NUM_LIGHTS=4, CNT_W=14)
REQ-029 SHALL cover a normal run: step_n=3, hold_n=5, HOLD_EN defined, start pulse at edge 0 -> lights 0001@3, 0011@6, 0111@9, 1111@12, 0000 with done=1@17, busy low@17, IDLE@18.
REQ-030 SHALL cover zero periods: step_n=0, hold_n=0 -> lamp per cycle at edges 1-4, done@5.
REQ-031 SHALL cover abort: abort at edge 7 of the REQ-029 run -> lights=0, busy=0 @7, no done pulse; restart works.
REQ-032 SHALL cover start priority and mid-sequence changes: start and abort together in IDLE -> stays IDLE; start at edge 5 mid-sequence -> ignored; step_n changed to 9 at edge 4 -> timing unchanged.
REQ-033 SHALL cover asynchronous reset: rst_n low between edges 8 and 9 -> outputs 0 before edge 9; no done pulse.
REQ-034 SHALL cover HOLD_EN undefined: step_n=3, hold_n=5 -> 1111@12, 0000 and done@13.
